// File: rtl/beep_scheduler.sv
// beep_scheduler: arbitrates alarm/chime/click onto one gated 500 Hz buzzer with per-source patterns.
// Optional snooze-on-cancel for the alarm is built when BEEP_SNOOZE_EN is defined.
module beep_scheduler #(
  parameter int CYCLES_PER_SEC = 1000,
  parameter int ALARM_SECS     = 5,
  parameter int CHIME_SECS     = 2,
  parameter int CLICK_MS       = 30,
  parameter int SNOOZE_SECS    = 60
) (
  input  logic       clk_1khz,
  input  logic       switch_clr,
  input  logic       req_alarm,
  input  logic       req_chime,
  input  logic       req_click,
  input  logic       cancel,
  output logic       beep,
  output logic       busy,
  output logic [1:0] src,
  output logic       snoozing
);
  localparam int MAX_AC = ALARM_SECS > CHIME_SECS ? ALARM_SECS : CHIME_SECS;
  localparam int MAX_S  = MAX_AC > SNOOZE_SECS ? MAX_AC : SNOOZE_SECS;
  localparam int MW     = $clog2(CYCLES_PER_SEC) > 0 ? $clog2(CYCLES_PER_SEC) : 1;
  localparam int SW     = $clog2(MAX_S) > 0 ? $clog2(MAX_S) : 1;
  localparam logic [MW-1:0] MS_LAST = MW'(CYCLES_PER_SEC - 1);
  localparam logic [MW-1:0] K_LAST  = MW'(CLICK_MS - 1);
  localparam logic [SW-1:0] A_LAST  = SW'(ALARM_SECS - 1);
  localparam logic [SW-1:0] C_LAST  = SW'(CHIME_SECS - 1);

  typedef enum logic [1:0] {IDLE = 2'b00, CLICK = 2'b01, CHIME = 2'b10, ALARM = 2'b11} state_t;

  state_t        state, base, nxt;
  logic [MW-1:0] ms_cnt;
  logic [SW-1:0] sec_cnt;
  logic          tone, chime_pend, nxt_pend, enter, done, stop, on_window, req_a, snz_fire;

  assign src   = state;
  assign busy  = state != IDLE;
  assign beep  = busy & on_window & tone;
  assign req_a = req_alarm | snz_fire;

  assign on_window = state == CLICK ||
                     (state == CHIME && ms_cnt < MW'(500)) ||
                     (state == ALARM && (ms_cnt < MW'(100) ||
                                         (ms_cnt >= MW'(200) && ms_cnt < MW'(300)) ||
                                         (ms_cnt >= MW'(400) && ms_cnt < MW'(500))));

  assign done = (state == ALARM && sec_cnt == A_LAST && ms_cnt == MS_LAST) ||
                (state == CHIME && sec_cnt == C_LAST && ms_cnt == MS_LAST) ||
                (state == CLICK && ms_cnt == K_LAST);

  // Cancel and natural termination settle first; requests are then judged against what remains.
  always_comb begin
    stop     = (cancel && busy) || done;
    base     = (cancel && busy) ? IDLE : done ? (chime_pend ? CHIME : IDLE) : state;
    nxt      = base;
    nxt_pend = stop ? 1'b0 : chime_pend;
    enter    = stop;
    if (req_a) begin
      nxt      = ALARM;
      nxt_pend = nxt_pend | req_chime;
      enter    = 1'b1;
    end else if (req_chime && base == ALARM) begin
      nxt_pend = 1'b1;
    end else if (req_chime) begin
      nxt   = CHIME;
      enter = 1'b1;
    end else if (req_click && (base == IDLE || base == CLICK)) begin
      nxt   = CLICK;
      enter = 1'b1;
    end
  end

  always_ff @(posedge clk_1khz) begin
    if (!switch_clr) begin
      state      <= IDLE;
      chime_pend <= 1'b0;
      ms_cnt     <= '0;
      sec_cnt    <= '0;
      tone       <= 1'b0;
    end else begin
      state      <= nxt;
      chime_pend <= nxt_pend;
      if (enter || nxt == IDLE) begin
        ms_cnt  <= '0;
        sec_cnt <= '0;
        tone    <= nxt != IDLE;
      end else begin
        ms_cnt  <= ms_cnt == MS_LAST ? '0 : ms_cnt + MW'(1);
        sec_cnt <= ms_cnt == MS_LAST ? sec_cnt + SW'(1) : sec_cnt;
        tone    <= ~tone;
      end
    end
  end

`ifdef BEEP_SNOOZE_EN
  localparam logic [SW-1:0] Z_LAST = SW'(SNOOZE_SECS - 1);
  logic          snz_q;
  logic [MW-1:0] snz_ms;
  logic [SW-1:0] snz_sec;
  assign snoozing = snz_q;
  assign snz_fire = snz_q && !cancel && snz_sec == Z_LAST && snz_ms == MS_LAST;
  always_ff @(posedge clk_1khz) begin
    if (!switch_clr || req_alarm || snz_fire || (cancel && snz_q && state != ALARM)) begin
      snz_q   <= 1'b0;
      snz_ms  <= '0;
      snz_sec <= '0;
    end else if (cancel && state == ALARM) begin
      snz_q   <= 1'b1;
      snz_ms  <= '0;
      snz_sec <= '0;
    end else if (snz_q) begin
      snz_ms  <= snz_ms == MS_LAST ? '0 : snz_ms + MW'(1);
      snz_sec <= snz_ms == MS_LAST ? snz_sec + SW'(1) : snz_sec;
    end
  end
`else
  assign snoozing = 1'b0;
  assign snz_fire = 1'b0;
`endif
endmodule

// File: tb/tb_beep_scheduler.sv
// tb_beep_scheduler: scoreboarded check of beep_scheduler (default build) against an age-based reference model.
module tb_beep_scheduler;
  localparam int CPS = 1000, A_S = 5, C_S = 2, K_MS = 30, Z_S = 60;

  logic       clk_1khz = 1'b0;
  logic       switch_clr = 1'b0, req_alarm = 1'b0, req_chime = 1'b0, req_click = 1'b0, cancel = 1'b0;
  logic       beep, busy, snoozing;
  logic [1:0] src;

  beep_scheduler #(.CYCLES_PER_SEC(CPS), .ALARM_SECS(A_S), .CHIME_SECS(C_S),
                   .CLICK_MS(K_MS), .SNOOZE_SECS(Z_S)) dut (
    .clk_1khz(clk_1khz), .switch_clr(switch_clr), .req_alarm(req_alarm), .req_chime(req_chime),
    .req_click(req_click), .cancel(cancel), .beep(beep), .busy(busy), .src(src), .snoozing(snoozing)
  );

  always #5 clk_1khz = ~clk_1khz;

  logic [4:0] exp_q[$];
  int checks = 0, passes = 0, cyc_no = 0;
  int cur = 0, age = 0;
  bit pend = 0;

  function automatic int dur(input int s);
    return s == 3 ? A_S * CPS : s == 2 ? C_S * CPS : K_MS;
  endfunction

  function automatic bit window(input int s, input int a);
    int ms;
    ms = a % CPS;
    return s == 1 || (s == 2 && ms < 500) || (s == 3 && ms < 500 && (ms / 100) % 2 == 0);
  endfunction

  // Sources are numbered by priority, so "may start" is simply winner >= current.
  task automatic model(input bit a, input bit c, input bit k, input bit x, input bit r);
    int win;
    bit fresh;
    fresh = 0;
    if (!r) begin
      cur = 0; pend = 0; age = 0;
      return;
    end
    if (x && cur != 0) begin
      cur = 0; pend = 0;
    end else if (cur != 0 && age == dur(cur) - 1) begin
      cur = pend ? 2 : 0; pend = 0; fresh = 1;
    end
    win = a ? 3 : c ? 2 : k ? 1 : 0;
    if (win != 0 && win >= cur) begin
      cur = win; fresh = 1;
      if (a && c) pend = 1;
    end else if (c && cur == 3) pend = 1;
    if (fresh) age = 0;
    else if (cur != 0) age++;
  endtask

  task automatic cyc(input bit a, input bit c, input bit k, input bit x, input bit r);
    logic b;
    req_alarm = a; req_chime = c; req_click = k; cancel = x; switch_clr = r;
    model(a, c, k, x, r);
    b = cur != 0 && age % 2 == 0 && window(cur, age);
    exp_q.push_back({b, cur != 0, 2'(cur), 1'b0});
    @(posedge clk_1khz);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0, 1);
  endtask

  initial begin
    logic [4:0] e, got;
    forever begin
      @(posedge clk_1khz);
      #1;
      cyc_no++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got = {beep, busy, src, snoozing};
        checks++;
        if (got === e) passes++;
        else $display("FAIL outputs cyc %0d {beep,busy,src,snoozing}: got %b want %b", cyc_no, got, e);
      end
    end
  end

  initial begin
    repeat (3) cyc(0, 0, 0, 0, 0);
    idle(10);
    cyc(1, 0, 0, 0, 1);
    idle(5010);
    cyc(0, 0, 1, 0, 1);
    idle(14);
    cyc(1, 0, 0, 0, 1);
    idle(5010);
    cyc(1, 1, 0, 0, 1);
    idle(7010);
    cyc(0, 1, 0, 0, 1);
    idle(500);
    cyc(0, 0, 1, 0, 1);
    idle(1510);
    cyc(1, 0, 0, 0, 1);
    idle(1199);
    cyc(0, 0, 0, 1, 1);
    idle(20);
    cyc(0, 1, 0, 0, 1);
    idle(700);
    cyc(0, 0, 0, 0, 0);
    idle(5);
    cyc(0, 1, 0, 0, 1);
    idle(2010);
    cyc(1, 0, 0, 0, 1);
    idle(100);
    cyc(0, 1, 0, 1, 1);
    idle(50);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 1, 0, 1);
    cyc(0, 0, 1, 0, 1);
    idle(40);
    for (int i = 0; i < 4000; i++)
      cyc($urandom_range(0, 1999) == 0, $urandom_range(0, 599) == 0, $urandom_range(0, 59) == 0,
          $urandom_range(0, 399) == 0, $urandom_range(0, 2999) != 0);
    idle(3);
    #5;
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
